// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and default width for serial_adder
package serial_adder_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell; ports a, b, cin -> sum, carry
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial a+b+cin; start/a/b/cin in, busy/done/sum/cout out
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH);
    logic [1:0]       state;
    logic [WIDTH-1:0] sa, sb, ps, nxt;
    logic [CW-1:0]    cnt;
    logic             carry, fs, fc, last;
    full_adder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .sum  (fs),
        .carry(fc)
    );
    assign nxt  = {fs, ps[WIDTH-1:1]};
    assign last = cnt == CW'(WIDTH - 1);
    assign busy = state == RUN;
    assign done = state == DONE;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == RUN) begin
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            ps    <= nxt;
            carry <= fc;
            cnt   <= last ? '0 : cnt + CW'(1);
            if (last) begin
                sum   <= nxt;
                cout  <= fc;
                state <= DONE;
            end
        end else if (start) begin
            sa    <= a;
            sb    <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
        end else begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4
module tb_serial_adder;
    typedef struct {
        logic [32:0] exp;
        int          due;
    } item_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start8 = 1'b0, cin8 = 1'b0, start4 = 1'b0, cin4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    logic busy8, done8, cout8, busy4, done4, cout4;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    item_t q8[$];
    item_t q4[$];
    logic [32:0] held8 = '0;
    logic [32:0] held4 = '0;
    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask
    always @(negedge clk) begin
        item_t e;
        logic  eb, ed;
        if (!rst) begin
            ed = q8.size() > 0 && cyc == q8[0].due;
            eb = q8.size() > 0 && cyc < q8[0].due;
            chk("busy8", 33'(busy8), 33'(eb));
            chk("done8", 33'(done8), 33'(ed));
            if (ed) begin
                e = q8.pop_front();
                held8 = e.exp;
            end
            chk("result8", {24'd0, cout8, sum8}, held8);
        end
    end
    always @(negedge clk) begin
        item_t e;
        logic  eb, ed;
        if (!rst) begin
            ed = q4.size() > 0 && cyc == q4[0].due;
            eb = q4.size() > 0 && cyc < q4[0].due;
            chk("busy4", 33'(busy4), 33'(eb));
            chk("done4", 33'(done4), 33'(ed));
            if (ed) begin
                e = q4.pop_front();
                held4 = e.exp;
            end
            chk("result4", {28'd0, cout4, sum4}, held4);
        end
    end
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        @(posedge clk); #1;
        q8.push_back('{exp: 33'(a) + 33'(b) + 33'(c), due: cyc + 8});
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
        a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
        @(posedge clk); #1;
        q4.push_back('{exp: 33'(a) + 33'(b) + 33'(c), due: cyc + 4});
        start4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
    endtask
    task automatic drain;
        for (int i = 0; i < 60 && (q8.size() != 0 || q4.size() != 0); i++) @(negedge clk);
        chk("drain_pending", 33'(q8.size() + q4.size()), 33'd0);
        @(negedge clk);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
    initial begin
        #12;
        chk("reset_busy_done", {busy8, done8, busy4, done4}, 33'd0);
        chk("reset_result", {cout8, sum8, cout4, sum4}, 33'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue8(8'hFF, 8'h01, 1'b0);
        drain();
        issue8(8'hA5, 8'h5A, 1'b1);
        drain();
        issue8(8'h00, 8'h00, 1'b1);
        drain();
        issue8(8'h12, 8'h34, 1'b0);
        repeat (2) @(posedge clk);
        #1 a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        drain();
        issue8(8'h11, 8'h22, 1'b1);
        repeat (8) @(posedge clk);
        #1 issue8(8'h80, 8'h80, 1'b0);
        drain();
        issue8(8'h5C, 8'h7E, 1'b1);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        q8.delete();
        held8 = '0;
        chk("async_rst_busy_done", {busy8, done8}, 33'd0);
        chk("async_rst_result", {cout8, sum8}, 33'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        issue8(8'h03, 8'h04, 1'b0);
        drain();
        for (int i = 0; i < 40; i++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            if (i % 3 == 0) drain();
            else begin
                repeat (8) @(posedge clk);
                #1;
            end
        end
        drain();
        for (int i = 0; i < 512; i++) begin
            issue4(4'(i), 4'(i >> 4), 1'(i >> 8));
            if (i != 511) begin
                repeat (4) @(posedge clk);
                #1;
            end
        end
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-cycle adder built around one instance of the team's existing full_adder cell.
- Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock; a carry flip-flop closes the loop around the full_adder.
- Sits directly downstream of full_adder: consumes its sum/carry every cycle and assembles them into a registered word result with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request: load a, b, cin and begin an addition
- a  input  WIDTH  operand A, sampled only on an accepted start
- b  input  WIDTH  operand B, sampled only on an accepted start
- cin  input  1  carry-in, sampled only on an accepted start
- busy  output  1  high while an addition is in progress (state RUN)
- done  output  1  one-cycle pulse: sum/cout just updated
- sum  output  WIDTH  registered result, a+b+cin mod 2^WIDTH
- cout  output  1  registered carry-out of the result

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst).
- Reset: state=IDLE; operand shift registers, partial-sum register, carry flop and bit counter = 0; busy=0, done=0, sum=0, cout=0.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE). Both are Moore outputs with no combinational path from start.
- IDLE: start=1 at an edge -> load sa<=a, sb<=b, carry<=cin, cnt<=0; go to RUN. start=0 -> stay.
- RUN, each edge:
  - full_adder inputs are sa[0], sb[0], carry.
  - Its sum output shifts into the MSB of the partial-sum register, which shifts right.
  - sa and sb shift right with 0 fill; carry<=full_adder carry; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1 (the last bit), the result is written directly: sum<=complete word including this bit, cout<=full_adder carry; go to DONE.
- DONE lasts exactly one cycle. start=1 -> accepted exactly as in IDLE (back-to-back operation, no idle gap). Otherwise go to IDLE.
- Latency: start accepted at edge k -> done high during the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start while busy (RUN): ignored. No effect on operands, counter or result.
- sum/cout change only on the edge entering DONE. They hold their value through IDLE and through the whole next RUN, so they stay stable for the consumer.
- a, b, cin are don't-care except at an accepted start; changing them mid-operation has no effect.
- Counter width is $clog2(WIDTH). It never counts past WIDTH-1 and is cleared on every accepted start.
- Reset mid-operation: immediate abort to the reset values above. No done pulse, sum/cout cleared. The next start after rst deasserts behaves normally.
- Arithmetic: {cout,sum} == a + b + cin, computed at WIDTH+1 bits.

Decomposition:
- Shared package serial_adder_pkg holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - default WIDTH constant
- One sub-module: the existing full_adder (ports a, b, cin, sum, carry), instantiated once, unchanged.
- Shift registers, counter and FSM stay flat in serial_adder.

Test Plan:
1. Reset, then start with a=8'hFF, b=8'h01, cin=0 -> busy high for 8 cycles; done pulses exactly 1 cycle, 9 cycles after the start edge; sum=8'h00, cout=1.
2. a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=1 -> sum=8'h01, cout=0. Prior result holds until the second done.
3. Start a=8'h12, b=8'h34, cin=0. At cycle 3 of RUN, pulse start with a=8'hFF, b=8'hFF -> the second start is ignored; result is sum=8'h46, cout=0; exactly one done pulse.
4. Assert start during the DONE cycle with a=8'h80, b=8'h80, cin=0 -> the new operation begins with no idle cycle; its done arrives 9 cycles later with sum=8'h00, cout=1.
5. Assert rst asynchronously (mid-cycle) during RUN -> busy, done, sum, cout go to 0 immediately with no done pulse. After release, 8'h03+8'h04 -> sum=8'h07, cout=0.
6. WIDTH=4: exhaustive over all 512 combinations of a, b, cin, run back-to-back -> every {cout,sum} equals a+b+cin, and done spacing is always 5 cycles.
